// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: M-stage load/store bridge onto a single-beat req/ack data bus, stalling the pipeline while busy.
// Optional macro DM_BUS_WBUF_EN enables a one-entry posted-write buffer (stores retire without stalling).
module dm_bus_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rdata_valid,
   output logic [31:0] rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

`ifdef DM_BUS_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t        r_state, w_next_state;
   logic [CW-1:0] r_cnt;
   logic          r_load;
   logic [1:0]    r_shift;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_stall, w_accept, w_bad_req, w_timeout, w_misaligned;
   logic [3:0]    w_be;
   logic [31:0]   w_lanes, w_rd_shifted;

   assign w_misaligned = (req_size == 2'b01) ? req_addr[0]
                                             : (req_size[1] && (req_addr[1:0] != 2'b00));
   assign w_rd_shifted = bus_rdata >> {r_shift, 3'b000};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_be    = 4'b1111;
      w_lanes = req_wdata;
      case (req_size)
         2'b00: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_lanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << req_addr[1:0];
            w_lanes = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_accept     = 1'b0;
      w_bad_req    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_misaligned) begin
                  w_bad_req    = 1'b1;
                  w_stall      = 1'b1;
                  w_next_state = S_RESP;
               end else begin
                  w_accept     = 1'b1;
                  w_stall      = !(WBUF && req_we);
                  w_next_state = req_we ? S_WR : S_RD;
               end
            end
         end
         S_RD: begin
            w_stall = 1'b1;
            if (bus_ack) begin
               w_next_state = S_RESP;
            end else if (r_cnt == LAST_CNT) begin
               w_timeout    = 1'b1;
               w_next_state = S_RESP;
            end
         end
         S_WR: begin
            // A posted write only holds the pipeline if a new access is waiting behind it.
            w_stall = WBUF ? req_valid : 1'b1;
            if (bus_ack || (r_cnt == LAST_CNT)) begin
               w_timeout    = !bus_ack;
               w_next_state = WBUF ? S_IDLE : S_RESP;
            end
         end
         S_RESP: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_load  <= 1'b0;
         r_shift <= 2'b00;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (((r_state == S_RD) || (r_state == S_WR)) && (w_next_state == r_state))
            r_cnt <= r_cnt + CW'(1);
         else
            r_cnt <= '0;

         if (w_accept) begin
            r_load  <= !req_we;
            r_shift <= req_addr[1:0];
            r_we    <= req_we;
            r_addr  <= {req_addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_lanes;
         end

         if (w_bad_req) begin
            r_load <= !req_we;
            r_err  <= 1'b1;
            if (!req_we) r_rdata <= ERR_DATA;
         end

         if ((r_state == S_RD) && bus_ack) r_rdata <= w_rd_shifted;

         if (w_timeout) begin
            r_err <= 1'b1;
            if (r_state == S_RD) r_rdata <= ERR_DATA;
         end
      end
   end

   assign stall       = w_stall;
   assign bus_req     = (r_state == S_RD) || (r_state == S_WR);
   assign rdata_valid = (r_state == S_RESP) && r_load;
   assign rdata       = r_rdata;
   assign bus_we      = r_we;
   assign bus_addr    = r_addr;
   assign bus_be      = r_be;
   assign bus_wdata   = r_wdata;
   assign bus_err     = r_err;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb_dm_bus_bridge: scoreboard bench for dm_bus_bridge with a queue-driven bus slave and a lane-level reference model.
// Build with DM_BUS_WBUF_EN defined to exercise the posted-write buffer as well.
module tb_dm_bus_bridge;

`ifdef DM_BUS_WBUF_EN
   localparam bit TB_WBUF = 1'b1;
`else
   localparam bit TB_WBUF = 1'b0;
`endif
   localparam int          T    = 4;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        stall, rdata_valid, bus_req, bus_we, bus_err;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   always #5 clk = ~clk;

   dm_bus_bridge #(.TIMEOUT(T), .ERR_DATA(ERRD)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   bus_t        bq[$];
   logic [31:0] rq[$];
   int          dq[$];
   logic [31:0] wq[$];

   int   total = 0;
   int   bad   = 0;
   logic exp_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // A lane is enabled when its byte offset falls inside [a, a+n).
   function automatic logic [3:0] model_be(input int n, input int a);
      logic [3:0] be;
      for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
      return be;
   endfunction

   // Lane i carries source byte (i mod n) of the right-aligned store data.
   function automatic logic [31:0] model_lanes(input int n, input logic [31:0] wd);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   // Bus slave: each new request pops an ack delay and a read word.
   logic        s_active = 1'b0;
   int          s_cnt = 0, s_delay = 0;
   logic [31:0] s_word = '0;
   initial begin
      forever begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (bus_req) begin
            if (!s_active) begin
               s_active = 1'b1;
               s_cnt    = 0;
               s_delay  = (dq.size() != 0) ? dq.pop_front() : 1000;
               s_word   = (wq.size() != 0) ? wq.pop_front() : 32'h0;
            end
            if (s_cnt == s_delay) begin
               bus_ack   = 1'b1;
               bus_rdata = s_word;
            end
            s_cnt++;
         end else begin
            s_active = 1'b0;
         end
      end
   end

   // Monitor: checks each new bus transaction and each load response against the queues.
   logic m_prev = 1'b0;
   bus_t m_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (bus_req && !m_prev) begin
            if (bq.size() == 0) begin
               check("unexpected_bus_req", 32'(bus_req), 32'd0);
            end else begin
               m_exp = bq.pop_front();
               check("bus_we",   32'(bus_we), 32'(m_exp.we));
               check("bus_addr", bus_addr,    m_exp.addr);
               check("bus_be",   32'(bus_be), 32'(m_exp.be));
               if (m_exp.we) check("bus_wdata", bus_wdata, m_exp.wdata);
            end
         end
         m_prev = bus_req;
         if (rdata_valid) begin
            if (rq.size() == 0) check("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
            else                check("rdata", rdata, rq.pop_front());
         end
      end
   end

   task automatic do_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int d, input logic [31:0] word);
      int   n, a, req_cycles, exp_stall, st, rc;
      logic mis, posted, timed_out, done;
      n         = nbytes(size);
      a         = int'(addr[1:0]);
      mis       = (a % n) != 0;
      posted    = TB_WBUF && we && !mis;
      timed_out = !mis && (d >= T);
      req_cycles = mis ? 0 : (timed_out ? T : d + 1);
      exp_stall  = mis ? 1 : (posted ? 0 : 1 + req_cycles);
      if (!mis) begin
         bq.push_back('{we, {addr[31:2], 2'b00}, model_be(n, a), model_lanes(n, wd)});
         dq.push_back(d);
         wq.push_back(word);
      end
      if (!we) rq.push_back((mis || timed_out) ? ERRD : (word >> (8 * a)));
      if (mis || timed_out) exp_err = 1'b1;

      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
      st = 0; rc = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (bus_req) rc++;
         if (stall) st++;
         else       done = 1'b1;
      end
      check("stall_cycles", st, exp_stall);
      if (!posted) check("bus_req_cycles", rc, req_cycles);
      check("rdata_valid", 32'(rdata_valid), 32'(!we));
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (posted) begin
         done = 1'b0;
         for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!bus_req) done = 1'b1;
         end
         check("posted_write_done", 32'(done), 32'd1);
      end
      check("bus_err", 32'(bus_err), 32'(exp_err));
   endtask

   task automatic rand_access(input bit allow_bad);
      logic [1:0]  size;
      logic [31:0] addr;
      int          off;
      size = 2'($urandom_range(0, 3));
      if (allow_bad)              off = $urandom_range(0, 3);
      else if (size == 2'b00)     off = $urandom_range(0, 3);
      else if (size == 2'b01)     off = 2 * $urandom_range(0, 1);
      else                        off = 0;
      addr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      do_access(1'($urandom_range(0, 1)), size, addr, $urandom,
                allow_bad ? $urandom_range(0, 5) : $urandom_range(0, 3), $urandom);
   endtask

   initial begin
      int   st;
      logic done;
      #12;
      check("rst_stall",       32'(stall),       32'd0);
      check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      check("rst_rdata",       rdata,            32'd0);
      check("rst_bus_req",     32'(bus_req),     32'd0);
      check("rst_bus_we",      32'(bus_we),      32'd0);
      check("rst_bus_addr",    bus_addr,         32'd0);
      check("rst_bus_be",      32'(bus_be),      32'd0);
      check("rst_bus_wdata",   bus_wdata,        32'd0);
      check("rst_bus_err",     32'(bus_err),     32'd0);
      @(negedge clk) reset = 1'b1;

      do_access(1'b0, 2'b10, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
      do_access(1'b0, 2'b00, 32'h0000_0103, 32'h0, 3, 32'hAABB_CCDD);
      do_access(1'b1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 1, 32'h0);

      if (TB_WBUF) begin
         // Posted store followed immediately by a load that must wait for the store ack.
         bq.push_back('{1'b1, 32'h0000_0600, 4'b1111, 32'h1111_2222});
         dq.push_back(2); wq.push_back(32'h0);
         bq.push_back('{1'b0, 32'h0000_0100, 4'b1111, 32'h0});
         dq.push_back(0); wq.push_back(32'h0BAD_F00D);
         rq.push_back(32'h0BAD_F00D);
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h600; req_wdata = 32'h1111_2222;
         @(negedge clk);
         check("posted_store_stall", 32'(stall), 32'd0);
         @(posedge clk); #1;
         req_we = 1'b0; req_addr = 32'h100;
         st = 0; done = 1'b0;
         for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (stall) st++;
            else       done = 1'b1;
         end
         check("load_behind_posted_stall", st, 5);
         @(posedge clk); #1;
         req_valid = 1'b0;
      end

      repeat (40) rand_access(1'b0);

      do_access(1'b0, 2'b10, 32'h0000_0400, 32'h0, 100, 32'h0);
      do_access(1'b0, 2'b10, 32'h0000_0101, 32'h0, 0, 32'h0);

      repeat (40) rand_access(1'b1);

      // Reset pulled mid-read: everything must return to reset values before the next edge.
      bq.push_back('{1'b0, 32'h0000_0300, 4'b1111, 32'h0});
      dq.push_back(1000); wq.push_back(32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
      done = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         if (bus_req) done = 1'b1;
      end
      check("midrst_bus_req_seen", 32'(done), 32'd1);
      @(posedge clk); #2;
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("midrst_bus_req", 32'(bus_req),     32'd0);
      check("midrst_stall",   32'(stall),       32'd0);
      check("midrst_bus_err", 32'(bus_err),     32'd0);
      check("midrst_rvalid",  32'(rdata_valid), 32'd0);
      check("midrst_rdata",   rdata,            32'd0);
      check("midrst_addr",    bus_addr,         32'd0);
      check("midrst_be",      32'(bus_be),      32'd0);
      exp_err = 1'b0;
      @(negedge clk);
      @(negedge clk) reset = 1'b1;

      do_access(1'b0, 2'b11, 32'h0000_0500, 32'h0, 1, 32'hCAFE_F00D);

      repeat (3) @(negedge clk);
      check("bus_queue_drained",   32'(bq.size()), 32'd0);
      check("rdata_queue_drained", 32'(rq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
